// File: rtl/tmem_crossbar_rr.sv
`default_nettype none
// ============================================================================
// Module      : tmem_crossbar_rr
// Description : Read crossbar from CORES vector cores to BANKS interleaved
//               TMEM banks. Each bank has its own arbiter, either round-robin
//               or fixed-priority. A tagged return pipeline is matched to the
//               bank read latency. Host writes are steered combinationally
//               into the addressed bank.
// Revision    : 1.0 - initial release
// ============================================================================
module tmem_crossbar_rr #(
    parameter int CORES    = 4,
    parameter int BANKS    = 4,
    parameter int ADR_W    = 32,
    parameter int DATA_W   = 32,
    parameter int BANK_LAT = 1,
    parameter int ARB_MODE = 0
) (
    input  logic                      Clock,
    input  logic                      Reset,
    input  logic [CORES-1:0]          iCoreReq,
    input  logic [CORES*ADR_W-1:0]    iCoreAdr,
    output logic [CORES-1:0]          oCoreGnt,
    output logic [CORES-1:0]          oCoreAck,
    output logic [CORES*DATA_W-1:0]   oCoreDat,
    output logic [BANKS-1:0]          oBankRdEn,
    output logic [BANKS*ADR_W-1:0]    oBankRdAdr,
    input  logic [BANKS*DATA_W-1:0]   iBankRdDat,
    input  logic                      iHostWe,
    input  logic [ADR_W-1:0]          iHostAdr,
    input  logic [DATA_W-1:0]         iHostDat,
    output logic [BANKS-1:0]          oBankWe,
    output logic [ADR_W-1:0]          oBankWrAdr,
    output logic [DATA_W-1:0]         oBankWrDat
);

    localparam int BANK_BITS = $clog2(BANKS);
    localparam int CIDX_W    = $clog2(CORES);

    // Per-core decode of the request address
    logic [BANK_BITS-1:0] w_core_bank [CORES];
    logic [ADR_W-1:0]     w_core_padr [CORES];

    // Per-bank arbitration result
    logic [BANKS-1:0]     w_bank_gnt;
    logic [CIDX_W-1:0]    w_bank_win  [BANKS];
    logic [ADR_W-1:0]     w_bank_padr [BANKS];

    // Round-robin last-winner pointers
    logic [CIDX_W-1:0]    ptr_q [BANKS];

    // Registered bank read port; rd_core_q travels alongside oBankRdEn and
    // acts as the entry point of the return tag pipeline
    logic [BANKS-1:0]     rd_en_q;
    logic [ADR_W-1:0]     rd_adr_q  [BANKS];
    logic [CIDX_W-1:0]    rd_core_q [BANKS];

    // Return tags: stage s is valid s+1 cycles after oBankRdEn, so the last
    // stage lines up with the bank data arriving BANK_LAT cycles later
    logic                 tag_v_q [BANKS][BANK_LAT];
    logic [CIDX_W-1:0]    tag_c_q [BANKS][BANK_LAT];

    // Per-core returned data, held between acknowledges
    logic [DATA_W-1:0]    core_dat_q [CORES];
    logic [DATA_W-1:0]    core_dat_d [CORES];

    // Split each core address into bank select and physical bank address
    always_comb begin
        for (int c = 0; c < CORES; c++) begin
            w_core_bank[c] = iCoreAdr[c*ADR_W +: BANK_BITS];
            w_core_padr[c] = iCoreAdr[c*ADR_W +: ADR_W] >> BANK_BITS;
        end
    end

    // Per-bank arbiter: scan cores starting after the last winner (round-robin)
    // or from core 0 (fixed priority); the first requester targeting the bank wins
    always_comb begin
        int idx;
        idx = 0;
        for (int b = 0; b < BANKS; b++) begin
            w_bank_gnt[b] = 1'b0;
            w_bank_win[b] = '0;
            for (int k = 0; k < CORES; k++) begin
                idx = (ARB_MODE != 0) ? k : ((int'(ptr_q[b]) + 1 + k) % CORES);
                if (!w_bank_gnt[b] && iCoreReq[idx] &&
                    (w_core_bank[idx] == BANK_BITS'(b))) begin
                    w_bank_gnt[b] = 1'b1;
                    w_bank_win[b] = CIDX_W'(idx);
                end
            end
            w_bank_padr[b] = w_core_padr[w_bank_win[b]];
        end
    end

    // A core is granted when the bank it targets picked it this cycle
    always_comb begin
        oCoreGnt = '0;
        for (int b = 0; b < BANKS; b++) begin
            if (w_bank_gnt[b]) begin
                oCoreGnt[w_bank_win[b]] = 1'b1;
            end
        end
    end

    // Register bank strobes/addresses, advance tags and update RR pointers
    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            rd_en_q <= '0;
            for (int b = 0; b < BANKS; b++) begin
                ptr_q[b]     <= CIDX_W'(CORES - 1);
                rd_adr_q[b]  <= '0;
                rd_core_q[b] <= '0;
                for (int s = 0; s < BANK_LAT; s++) begin
                    tag_v_q[b][s] <= 1'b0;
                    tag_c_q[b][s] <= '0;
                end
            end
        end else begin
            rd_en_q <= w_bank_gnt;
            for (int b = 0; b < BANKS; b++) begin
                if (w_bank_gnt[b]) begin
                    rd_adr_q[b]  <= w_bank_padr[b];
                    rd_core_q[b] <= w_bank_win[b];
                    if (ARB_MODE == 0) begin
                        ptr_q[b] <= w_bank_win[b];
                    end
                end
                tag_v_q[b][0] <= rd_en_q[b];
                tag_c_q[b][0] <= rd_core_q[b];
                for (int s = 1; s < BANK_LAT; s++) begin
                    tag_v_q[b][s] <= tag_v_q[b][s-1];
                    tag_c_q[b][s] <= tag_c_q[b][s-1];
                end
            end
        end
    end

    // Route each bank's data to the core named by its emerging tag
    always_comb begin
        oCoreAck = '0;
        for (int c = 0; c < CORES; c++) begin
            core_dat_d[c] = core_dat_q[c];
        end
        for (int b = 0; b < BANKS; b++) begin
            if (tag_v_q[b][BANK_LAT-1]) begin
                oCoreAck[tag_c_q[b][BANK_LAT-1]]   = 1'b1;
                core_dat_d[tag_c_q[b][BANK_LAT-1]] = iBankRdDat[b*DATA_W +: DATA_W];
            end
        end
        for (int c = 0; c < CORES; c++) begin
            oCoreDat[c*DATA_W +: DATA_W] = core_dat_d[c];
        end
    end

    // Hold returned data so non-acked cores keep their last value
    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            for (int c = 0; c < CORES; c++) begin
                core_dat_q[c] <= '0;
            end
        end else begin
            for (int c = 0; c < CORES; c++) begin
                core_dat_q[c] <= core_dat_d[c];
            end
        end
    end

    // Flatten the registered bank read port onto the output bus
    always_comb begin
        oBankRdEn = rd_en_q;
        for (int b = 0; b < BANKS; b++) begin
            oBankRdAdr[b*ADR_W +: ADR_W] = rd_adr_q[b];
        end
    end

    // Host write steering: one-hot enable on the addressed bank
    always_comb begin
        oBankWe = '0;
        for (int b = 0; b < BANKS; b++) begin
            if (iHostWe && (iHostAdr[BANK_BITS-1:0] == BANK_BITS'(b))) begin
                oBankWe[b] = 1'b1;
            end
        end
        oBankWrAdr = iHostAdr >> BANK_BITS;
        oBankWrDat = iHostDat;
    end

endmodule
`default_nettype wire

// File: tb/tb_tmem_crossbar_rr.sv
`default_nettype none
// ============================================================================
// Module      : tb_tmem_crossbar_rr
// Description : Self-checking bench for tmem_crossbar_rr. One round-robin
//               instance (BANK_LAT=1) is driven by directed and random
//               requests against a reference model; a fixed-priority
//               instance (BANK_LAT=3) covers priority and mid-flight reset.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_tmem_crossbar_rr;

    logic clk;
    logic rst0, rst1;

    // Instance 0: round-robin, BANK_LAT=1
    logic [3:0]   req0, gnt0, ack0, rden0, bwe0;
    logic [127:0] adr0, dat0, rdadr0, bdat0;
    logic         hwe;
    logic [31:0]  hadr, hdat, bwradr0, bwrdat0;

    // Instance 1: fixed priority, BANK_LAT=3
    logic [3:0]   req1, gnt1, ack1, rden1, bwe1;
    logic [127:0] adr1, dat1, rdadr1, bdat1;
    logic         hwe1;
    logic [31:0]  hadr1, hdat1, bwradr1, bwrdat1;

    tmem_crossbar_rr #(.CORES(4), .BANKS(4), .ADR_W(32), .DATA_W(32),
                       .BANK_LAT(1), .ARB_MODE(0)) dut0 (
        .Clock(clk), .Reset(rst0),
        .iCoreReq(req0), .iCoreAdr(adr0), .oCoreGnt(gnt0),
        .oCoreAck(ack0), .oCoreDat(dat0),
        .oBankRdEn(rden0), .oBankRdAdr(rdadr0), .iBankRdDat(bdat0),
        .iHostWe(hwe), .iHostAdr(hadr), .iHostDat(hdat),
        .oBankWe(bwe0), .oBankWrAdr(bwradr0), .oBankWrDat(bwrdat0)
    );

    tmem_crossbar_rr #(.CORES(4), .BANKS(4), .ADR_W(32), .DATA_W(32),
                       .BANK_LAT(3), .ARB_MODE(1)) dut1 (
        .Clock(clk), .Reset(rst1),
        .iCoreReq(req1), .iCoreAdr(adr1), .oCoreGnt(gnt1),
        .oCoreAck(ack1), .oCoreDat(dat1),
        .oBankRdEn(rden1), .oBankRdAdr(rdadr1), .iBankRdDat(bdat1),
        .iHostWe(hwe1), .iHostAdr(hadr1), .iHostDat(hdat1),
        .oBankWe(bwe1), .oBankWrAdr(bwradr1), .oBankWrDat(bwrdat1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Bank RAM contents shared by both instances
    logic [31:0] mem [4][256];

    // Bank RAM model, latency 1
    always @(posedge clk) begin
        for (int b = 0; b < 4; b++) begin
            if (rden0[b]) bdat0[b*32 +: 32] <= mem[b][rdadr0[b*32 +: 8]];
        end
    end

    // Bank RAM model, latency 3
    logic [127:0] p1_s1, p1_s2;
    always @(posedge clk) begin
        for (int b = 0; b < 4; b++) begin
            p1_s1[b*32 +: 32] <= rden1[b] ? mem[b][rdadr1[b*32 +: 8]] : 32'hBAD0BAD0;
        end
        p1_s2 <= p1_s1;
        bdat1 <= p1_s2;
    end

    int passed = 0;
    int total  = 0;

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    // Reference model state for instance 0
    int          cyc;
    int          m_ptr [4];
    logic [31:0] m_dat [4];
    logic [3:0]  exp_rden  [8];
    logic [31:0] exp_rdadr [8][4];
    logic [3:0]  exp_ack   [8];
    logic [31:0] exp_adat  [8][4];
    logic [3:0]  s_req, last_gnt;
    logic [31:0] s_adr [4];

    // One cycle on instance 0: check registered/return outputs, apply
    // s_req/s_adr, predict grants and schedule the resulting reads/acks
    task automatic step0();
        int slot, nx1, nx2, best, bestd, d;
        logic [3:0]  g;
        logic [31:0] padr;
        @(posedge clk); #1;
        cyc++;
        slot = cyc % 8;
        nx1  = (cyc + 1) % 8;
        nx2  = (cyc + 2) % 8;
        check("rden", rden0, exp_rden[slot]);
        for (int b = 0; b < 4; b++)
            if (exp_rden[slot][b]) check("rdadr", rdadr0[b*32 +: 32], exp_rdadr[slot][b]);
        for (int c = 0; c < 4; c++)
            if (exp_ack[slot][c]) m_dat[c] = exp_adat[slot][c];
        check("ack", ack0, exp_ack[slot]);
        check("dat", dat0, {m_dat[3], m_dat[2], m_dat[1], m_dat[0]});
        exp_rden[slot] = '0;
        exp_ack[slot]  = '0;

        req0 = s_req;
        for (int c = 0; c < 4; c++) adr0[c*32 +: 32] = s_adr[c];
        #1;
        g = '0;
        for (int b = 0; b < 4; b++) begin
            best  = -1;
            bestd = 99;
            for (int c = 0; c < 4; c++) begin
                if (s_req[c] && (s_adr[c] % 4) == b) begin
                    // position of core c in the search order after the pointer
                    d = (c - m_ptr[b] - 1 + 8) % 4;
                    if (d < bestd) begin bestd = d; best = c; end
                end
            end
            if (best >= 0) begin
                padr = s_adr[best] / 4;
                g[best] = 1'b1;
                m_ptr[b] = best;
                exp_rden[nx1][b]     = 1'b1;
                exp_rdadr[nx1][b]    = padr;
                exp_ack[nx2][best]   = 1'b1;
                exp_adat[nx2][best]  = mem[b][padr % 256];
            end
        end
        check("gnt", gnt0, g);
        last_gnt = g;
    endtask

    initial begin
        for (int b = 0; b < 4; b++)
            for (int a = 0; a < 256; a++) mem[b][a] = $urandom;
        mem[3][4] = 32'hDEADBEEF;
        rst0 = 1'b1; rst1 = 1'b1;
        req0 = '0; adr0 = '0; req1 = '0; adr1 = '0;
        hwe = 1'b0; hadr = '0; hdat = '0;
        hwe1 = 1'b0; hadr1 = '0; hdat1 = '0;
        bdat0 = '0;
        cyc = 0; s_req = '0; last_gnt = '0;
        for (int i = 0; i < 4; i++) begin m_ptr[i] = 3; m_dat[i] = '0; s_adr[i] = '0; end
        for (int i = 0; i < 8; i++) begin exp_rden[i] = '0; exp_ack[i] = '0; end

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        check("rst_rden", rden0, 4'b0);
        check("rst_rdadr", rdadr0, 128'b0);
        check("rst_ack", ack0, 4'b0);
        check("rst_dat", dat0, 128'b0);
        check("rst_gnt", gnt0, 4'b0);
        check("rst_bwe", bwe0, 4'b0);
        check("rst_rden1", rden1, 4'b0);
        rst0 = 1'b0; rst1 = 1'b0;

        // Single read of 0x13: bank 3, physical address 4
        s_req = 4'b0001; s_adr[0] = 32'h13;
        step0();
        check("t1_gnt", gnt0, 4'b0001);
        s_req = 4'b0000;
        step0();
        check("t1_rden", rden0, 4'b1000);
        check("t1_rdadr", rdadr0[127:96], 32'h4);
        step0();
        check("t1_ack", ack0, 4'b0001);
        check("t1_dat", dat0[31:0], 32'hDEADBEEF);

        // Four cores contending for bank 1: rotating grants 0,1,2,3,...
        s_req = 4'b1111;
        for (int c = 0; c < 4; c++) s_adr[c] = (32'($urandom_range(0, 63)) << 2) | 32'h1;
        for (int i = 0; i < 12; i++) begin
            step0();
            check("rr_order", gnt0, 4'b0001 << (i % 4));
            for (int c = 0; c < 4; c++)
                if (last_gnt[c]) s_adr[c] = (32'($urandom_range(0, 63)) << 2) | 32'h1;
        end
        s_req = '0;
        repeat (3) step0();

        // All four banks granted in the same cycle
        s_req = 4'b1111;
        for (int c = 0; c < 4; c++) s_adr[c] = 32'(c);
        step0();
        check("par_gnt", gnt0, 4'b1111);
        s_req = '0;
        step0();
        step0();
        check("par_ack", ack0, 4'b1111);

        // Random traffic; requests held until granted
        for (int i = 0; i < 300; i++) begin
            for (int c = 0; c < 4; c++) begin
                if (!s_req[c] || last_gnt[c]) begin
                    s_req[c] = 1'($urandom_range(0, 1));
                    s_adr[c] = 32'($urandom_range(0, 1023));
                end
            end
            step0();
        end
        s_req = '0;
        repeat (3) step0();

        // Host write steering
        hwe = 1'b1; hadr = 32'h26; hdat = 32'h55;
        #1;
        check("hw_we", bwe0, 4'b0100);
        check("hw_adr", bwradr0, 32'h9);
        check("hw_dat", bwrdat0, 32'h55);
        hadr = 32'h3;
        #1;
        check("hw_we3", bwe0, 4'b1000);
        hwe = 1'b0;
        #1;
        check("hw_off", bwe0, 4'b0000);

        // Fixed priority: core 0 beats core 2 on bank 2 until it drops
        @(posedge clk); #1;
        req1 = 4'b0101;
        adr1[31:0] = 32'h2; adr1[95:64] = 32'h6;
        #1;
        check("fp_gnt0", gnt1, 4'b0001);
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            adr1[31:0] = 32'h2 + 32'((i + 1) * 4);
            #1;
            check("fp_gnt0", gnt1, 4'b0001);
        end
        @(posedge clk); #1;
        req1 = 4'b0100;
        #1;
        check("fp_gnt2", gnt1, 4'b0100);
        @(posedge clk); #1;
        req1 = 4'b0000;
        check("fp_ack_a", ack1, 4'b0001);
        @(posedge clk); #1;
        check("fp_ack_b", ack1, 4'b0001);
        @(posedge clk); #1;
        check("fp_ack_c", ack1, 4'b0001);
        @(posedge clk); #1;
        check("fp_ack2", ack1, 4'b0100);
        check("fp_dat2", dat1[95:64], mem[2][1]);
        @(posedge clk); #1;
        check("fp_idle", ack1, 4'b0000);
        repeat (2) @(posedge clk);

        // Reset one cycle after a grant: the in-flight read never acks
        #1;
        req1 = 4'b0001; adr1[31:0] = 32'h1;
        #1;
        check("rs_gnt", gnt1, 4'b0001);
        @(posedge clk); #1;
        req1 = 4'b0000;
        check("rs_rden", rden1, 4'b0010);
        rst1 = 1'b1;
        #1;
        check("rs_clr", rden1, 4'b0000);
        check("rs_ack", ack1, 4'b0000);
        for (int i = 0; i < 8; i++) begin
            @(posedge clk); #1;
            if (i == 1) rst1 = 1'b0;
            check("rs_noack", ack1, 4'b0000);
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
`default_nettype wire
